writeback_stage: RTL and testbench

- Final pipeline stage, directly upstream of the CPU register file.
- Accepts completed instructions from execute over a valid/ready handshake.
- For loads, issues a word read to data memory, waits a variable latency, then extracts and sign/zero-extends the requested lane.
- Drives the register file write, upper-immediate and link (r31) ports as a one-cycle pulse. Exposes the pending destination for hazard detection.

---
 rtl/writeback_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_writeback_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results directly, and performs loads through a
// single-word data memory read with lane extraction and sign/zero extension.
// All register-file and memory-request outputs come straight from flops.
module writeback_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_wdata,
  input  logic        in_wren,
  input  logic        in_is_upper,
  input  logic        in_is_load,
  input  logic [1:0]  in_load_size,
  input  logic        in_load_unsigned,
  input  logic        in_jal,
  input  logic [31:0] in_link,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wren,
  output logic        rf_is_upper,
  output logic        rf_jal_wren,
  output logic [31:0] rf_jal_data,
  output logic        pending_valid,
  output logic [4:0]  pending_waddr,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT} state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Context of the load in flight, captured at accept time.
  logic [4:0]  ld_waddr_q, ld_waddr_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;
  logic        ld_wren_q, ld_wren_d;
  logic        ld_jal_q, ld_jal_d;
  logic [31:0] ld_link_q, ld_link_d;

  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        rf_wren_q, rf_wren_d;
  logic        rf_is_upper_q, rf_is_upper_d;
  logic        rf_jal_wren_q, rf_jal_wren_d;
  logic [31:0] rf_jal_data_q, rf_jal_data_d;

  logic        err_q, err_d;

  logic        load_done, load_timeout;

  // Select the addressed lane of a little-endian word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [1:0]  size,
                                          input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Next-state, load bookkeeping and registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_waddr_d    = ld_waddr_q;
    ld_off_d      = ld_off_q;
    ld_size_d     = ld_size_q;
    ld_uns_d      = ld_uns_q;
    ld_wren_d     = ld_wren_q;
    ld_jal_d      = ld_jal_q;
    ld_link_d     = ld_link_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = '0;
    rf_waddr_d    = '0;
    rf_wdata_d    = '0;
    rf_wren_d     = 1'b0;
    rf_is_upper_d = 1'b0;
    rf_jal_wren_d = 1'b0;
    rf_jal_data_d = '0;
    err_d         = err_q;
    load_done     = 1'b0;
    load_timeout  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            ld_waddr_d = in_waddr;
            ld_off_d   = in_wdata[1:0];
            ld_size_d  = in_load_size;
            ld_uns_d   = in_load_unsigned;
            ld_wren_d  = in_wren;
            ld_jal_d   = in_jal;
            ld_link_d  = in_link;
            mem_req_d  = 1'b1;
            mem_addr_d = {in_wdata[31:2], 2'b00};
            cnt_d      = '0;
            state_d    = MEM_REQ;
          end else begin
            rf_waddr_d    = in_waddr;
            rf_wdata_d    = in_wdata;
            rf_is_upper_d = in_is_upper;
            // The link write to r31 takes priority over a regular write to r31.
            rf_wren_d     = in_wren && (in_waddr != 5'd0) && !(in_jal && in_waddr == 5'd31);
            rf_jal_wren_d = in_jal;
            rf_jal_data_d = in_jal ? in_link : '0;
          end
        end
      end
      MEM_REQ: begin
        cnt_d = '0;
        if (mem_rvalid) begin
          load_done = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid) begin
          load_done = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q + 8'd1 >= TIMEOUT_CNT) begin
          load_timeout = 1'b1;
          err_d        = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_done) begin
      rf_waddr_d = ld_waddr_q;
      rf_wdata_d = extract(mem_rdata, ld_off_q, ld_size_q, ld_uns_q);
      rf_wren_d  = ld_wren_q && (ld_waddr_q != 5'd0) && !(ld_jal_q && ld_waddr_q == 5'd31);
    end
    // An abandoned load still delivers its link value in its writeback slot.
    if (load_done || load_timeout) begin
      rf_jal_wren_d = ld_jal_q;
      rf_jal_data_d = ld_jal_q ? ld_link_q : '0;
    end
  end

  // State and output registers; reset abandons any load in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ld_waddr_q    <= '0;
      ld_off_q      <= '0;
      ld_size_q     <= '0;
      ld_uns_q      <= 1'b0;
      ld_wren_q     <= 1'b0;
      ld_jal_q      <= 1'b0;
      ld_link_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      rf_wren_q     <= 1'b0;
      rf_is_upper_q <= 1'b0;
      rf_jal_wren_q <= 1'b0;
      rf_jal_data_q <= '0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_waddr_q    <= ld_waddr_d;
      ld_off_q      <= ld_off_d;
      ld_size_q     <= ld_size_d;
      ld_uns_q      <= ld_uns_d;
      ld_wren_q     <= ld_wren_d;
      ld_jal_q      <= ld_jal_d;
      ld_link_q     <= ld_link_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_wren_q     <= rf_wren_d;
      rf_is_upper_q <= rf_is_upper_d;
      rf_jal_wren_q <= rf_jal_wren_d;
      rf_jal_data_q <= rf_jal_data_d;
      err_q         <= err_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign pending_valid = (state_q != IDLE);
  assign pending_waddr = pending_valid ? ld_waddr_q : 5'd0;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign rf_wren       = rf_wren_q;
  assign rf_is_upper   = rf_is_upper_q;
  assign rf_jal_wren   = rf_jal_wren_q;
  assign rf_jal_data   = rf_jal_data_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized ALU/load traffic
// compared against an arithmetic reference model of the load extraction rules.
module tb_writeback_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        in_wren, in_is_upper, in_is_load;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned, in_jal;
  logic [31:0] in_link;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wren, rf_is_upper, rf_jal_wren;
  logic [31:0] rf_jal_data;
  logic        pending_valid;
  logic [4:0]  pending_waddr;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  writeback_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_waddr(in_waddr), .in_wdata(in_wdata), .in_wren(in_wren),
    .in_is_upper(in_is_upper), .in_is_load(in_is_load),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_jal(in_jal), .in_link(in_link),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wren(rf_wren),
    .rf_is_upper(rf_is_upper), .rf_jal_wren(rf_jal_wren),
    .rf_jal_data(rf_jal_data),
    .pending_valid(pending_valid), .pending_waddr(pending_waddr),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: pick the lane with plain shifts/masks, sign-extend by subtraction.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int unsigned sh;
    if (sz == 2'd0) begin
      sh = (a % 4) * 8;
      v  = (d >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      sh = ((a / 2) % 2) * 16;
      v  = (d >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic ref_wren(input logic wren, input logic [4:0] wa, input logic jal);
    return wren && (wa != 0) && !(jal && wa == 31);
  endfunction

  task automatic clear_inputs();
    in_valid = 0; in_waddr = 0; in_wdata = 0; in_wren = 0; in_is_upper = 0;
    in_is_load = 0; in_load_size = 0; in_load_unsigned = 0; in_jal = 0; in_link = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  // Presents one non-load for a single cycle; in_valid is left to the caller.
  task automatic send_alu(input logic [4:0] wa, input logic [31:0] wd, input logic wren,
                          input logic upper, input logic jal, input logic [31:0] link);
    check("alu_in_ready", in_ready, 1);
    in_valid = 1; in_is_load = 0; in_waddr = wa; in_wdata = wd; in_wren = wren;
    in_is_upper = upper; in_jal = jal; in_link = link;
    step();
    check("alu_wren", rf_wren, ref_wren(wren, wa, jal));
    check("alu_waddr", rf_waddr, wa);
    check("alu_wdata", rf_wdata, wd);
    check("alu_upper", rf_is_upper, upper);
    check("alu_jal_wren", rf_jal_wren, jal);
    if (jal) check("alu_jal_data", rf_jal_data, link);
  endtask

  // Full load transaction; lat = cycles after the mem_req cycle before rvalid.
  task automatic send_load(input logic [4:0] wa, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input logic jal, input logic [31:0] link,
                           input int lat, input logic [31:0] data);
    check("ld_in_ready", in_ready, 1);
    in_valid = 1; in_is_load = 1; in_waddr = wa; in_wdata = addr; in_wren = 1;
    in_load_size = sz; in_load_unsigned = uns; in_jal = jal; in_link = link;
    in_is_upper = 1;
    step();
    in_valid = 0;
    check("ld_mem_req", mem_req, 1);
    check("ld_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
    check("ld_pending", pending_valid, 1);
    check("ld_pending_waddr", pending_waddr, wa);
    check("ld_ready_low", in_ready, 0);
    for (int k = 0; k <= lat; k++) begin
      mem_rvalid = (k == lat);
      mem_rdata  = (k == lat) ? data : $urandom;
      step();
      if (k < lat) begin
        check("ld_wait_ready", in_ready, 0);
        check("ld_wait_pending", pending_valid, 1);
        check("ld_wait_req", mem_req, 0);
        check("ld_wait_wren", rf_wren, 0);
      end
    end
    mem_rvalid = 0;
    check("ld_wren", rf_wren, ref_wren(1'b1, wa, jal));
    check("ld_waddr", rf_waddr, wa);
    check("ld_wdata", rf_wdata, ref_load(data, addr, sz, uns));
    check("ld_upper", rf_is_upper, 0);
    check("ld_jal_wren", rf_jal_wren, jal);
    if (jal) check("ld_jal_data", rf_jal_data, link);
    check("ld_done_ready", in_ready, 1);
    check("ld_done_pending", pending_valid, 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_wren", rf_wren, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_rf_jal", rf_jal_wren, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_pending", pending_valid, 0);
    check("rst_err", err_timeout, 0);
    rst = 0;
    step();

    // Single write, then confirm it lasted only one cycle.
    send_alu(5'd5, 32'h1234_5678, 1, 0, 0, 0);
    in_valid = 0;
    step();
    check("alu_pulse_end", rf_wren, 0);

    // Back-to-back non-loads, including r0 and an upper-immediate.
    send_alu(5'd1, 32'd1, 1, 0, 0, 0);
    send_alu(5'd2, 32'd2, 1, 1, 0, 0);
    send_alu(5'd0, 32'd3, 1, 0, 0, 0);
    in_valid = 0;
    step();
    check("b2b_end", rf_wren, 0);

    // Directed loads.
    send_load(5'd7, 32'h0000_0103, 2'b00, 0, 0, 0, 3, 32'h80FF_7F01);
    send_load(5'd8, 32'h0000_0202, 2'b01, 1, 0, 0, 2, 32'hBEEF_1234);
    send_load(5'd9, 32'h0000_0300, 2'b10, 0, 0, 0, 0, 32'hCAFE_F00D);

    // Link write wins over a regular write to r31.
    send_alu(5'd31, 32'h999, 1, 0, 1, 32'h44);
    in_valid = 0;
    step();

    // Timeout: no rvalid; jal link still delivered in the abandoned slot.
    in_valid = 1; in_is_load = 1; in_waddr = 5'd12; in_wdata = 32'h400; in_wren = 1;
    in_load_size = 2'b10; in_jal = 1; in_link = 32'h1234;
    step();
    in_valid = 0;
    for (int k = 0; k < TO; k++) begin
      step();
      check("to_wait_ready", in_ready, 0);
    end
    step();
    check("to_ready", in_ready, 1);
    check("to_err", err_timeout, 1);
    check("to_rf_wren", rf_wren, 0);
    check("to_jal_wren", rf_jal_wren, 1);
    check("to_jal_data", rf_jal_data, 32'h1234);
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 0;
    check("late_rvalid_wren", rf_wren, 0);
    check("late_rvalid_ready", in_ready, 1);

    // Randomized mix of non-loads and loads (latency up to the timeout boundary).
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_alu(5'($urandom), $urandom, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), $urandom);
        in_valid = 0;
        if ($urandom_range(0, 1) == 0) step();
      end else begin
        send_load(5'($urandom), $urandom, 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, TO), $urandom);
      end
    end
    check("err_sticky", err_timeout, 1);

    // Reset during MEM_WAIT abandons the load; later rvalid is ignored.
    clear_inputs();
    in_valid = 1; in_is_load = 1; in_waddr = 5'd20; in_wdata = 32'h500; in_wren = 1;
    step();
    in_valid = 0;
    step();
    check("mw_pending", pending_valid, 1);
    rst = 1;
    #1;
    check("mw_rst_pending", pending_valid, 0);
    check("mw_rst_ready", in_ready, 1);
    check("mw_rst_err", err_timeout, 0);
    step();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 0;
    check("mw_late_wren", rf_wren, 0);
    check("mw_late_wdata", rf_wdata, 0);
    check("mw_late_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
